// File: rtl/delay_pkg.sv
// Shared sizing and delay-clamp helpers for the variable delay line.
package delay_pkg;

    // Bits needed to hold any delay value 0..max_delay.
    function automatic int unsigned dw_f(input int unsigned max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Ring address width; a one-entry ring still needs a 1-bit pointer.
    function automatic int unsigned aw_f(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_delay);
        return (req > max_delay) ? max_delay : req;
    endfunction

endpackage

// File: rtl/delay_ring_ram.sv
// Sample ring storage: one write port, async read port, per-entry valid bits
// with a single-cycle clear-all (data words are never reset).
module delay_ring_ram
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = aw_f(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_all,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wvalid,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_c,
    output logic             rvalid_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Clear-all wins over a write in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[waddr] = wvalid;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c  = mem_q[raddr];
    assign rvalid_c = valid_q[raddr];

endmodule

// File: rtl/var_delay_line.sv
// Strobe-driven variable delay line (0..MAX_DELAY strobes) over a sample ring.
// Define VAR_DELAY_FLUSH_EN to add the flush input.
module var_delay_line
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned MAX_DELAY  = 16,
    parameter int unsigned INIT_DELAY = 1,
    localparam int unsigned DW        = dw_f(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [DW-1:0]    delay,
    input  logic             delay_load,
`ifdef VAR_DELAY_FLUSH_EN
    input  logic             flush,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [DW-1:0]    cur_delay
);

    localparam int unsigned AW       = aw_f(MAX_DELAY);
    localparam int unsigned PW       = DW + 1;
    localparam logic [DW-1:0] INIT_D = DW'(clamp_delay(INIT_DELAY, MAX_DELAY));
    localparam logic [AW-1:0] WRAP   = AW'(MAX_DELAY - 1);
    localparam logic [DW-1:0] FILL_MAX = DW'(MAX_DELAY);

    if (MAX_DELAY < 1) begin : g_bad_max
        $error("var_delay_line: MAX_DELAY must be at least 1");
    end

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [DW-1:0]    cur_delay_q, cur_delay_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic [DW-1:0]    load_delay_c;
    logic [DW-1:0]    eff_delay_c;
    logic [DW-1:0]    eff_fill_c;
    logic [PW-1:0]    rd_idx_c;
    logic [AW-1:0]    raddr_c;
    logic             flush_c;
    logic             ram_clear_c;
    logic             ram_we_c;
    logic             ring_hit_c;
    logic [WIDTH-1:0] ram_rdata_c;
    logic             ram_rvalid_c;

`ifdef VAR_DELAY_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // A load takes effect on a coincident strobe, which then sees an empty fill.
    assign load_delay_c = DW'(clamp_delay(32'(delay), MAX_DELAY));
    assign eff_delay_c  = delay_load ? load_delay_c : cur_delay_q;
    assign eff_fill_c   = delay_load ? '0 : fill_q;

    // Read index (wptr - D) mod MAX_DELAY without a divider.
    always_comb begin
        rd_idx_c = PW'(wptr_q) + PW'(MAX_DELAY) - PW'(eff_delay_c);
        if (rd_idx_c >= PW'(MAX_DELAY)) begin
            rd_idx_c = rd_idx_c - PW'(MAX_DELAY);
        end
    end

    assign raddr_c     = AW'(rd_idx_c);
    assign ram_clear_c = reset | flush_c;
    assign ram_we_c    = en & ~ram_clear_c;
    assign ring_hit_c  = ram_rvalid_c & (eff_fill_c >= eff_delay_c);

    delay_ring_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DELAY)
    ) u_ring (
        .clk       (clk),
        .clear_all (ram_clear_c),
        .we        (ram_we_c),
        .waddr     (wptr_q),
        .wdata     (din),
        .wvalid    (din_valid),
        .raddr     (raddr_c),
        .rdata_c   (ram_rdata_c),
        .rvalid_c  (ram_rvalid_c)
    );

    // Next-state: everything holds unless a load, flush or strobe acts.
    always_comb begin
        wptr_d       = wptr_q;
        fill_d       = fill_q;
        cur_delay_d  = cur_delay_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (delay_load) begin
            cur_delay_d = load_delay_c;
            fill_d      = '0;
        end

        if (flush_c) begin
            fill_d       = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
        end else if (en) begin
            wptr_d = (wptr_q == WRAP) ? '0 : wptr_q + AW'(1);
            if (delay_load) begin
                fill_d = DW'(1);
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + DW'(1);
            end

            if (eff_delay_c == '0) begin
                dout_valid_d = din_valid;
                dout_d       = din_valid ? din : '0;
            end else begin
                dout_valid_d = ring_hit_c;
                dout_d       = ring_hit_c ? ram_rdata_c : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q       <= '0;
            fill_q       <= '0;
            cur_delay_q  <= INIT_D;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            cur_delay_q  <= cur_delay_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cur_delay  = cur_delay_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboard bench for var_delay_line: a history-queue model predicts each output.
module tb_var_delay_line;

    localparam int unsigned WIDTH      = 24;
    localparam int unsigned MAX_DELAY  = 16;
    localparam int unsigned INIT_DELAY = 1;
    localparam int unsigned DW         = 5;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             v;
    } smp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic [DW-1:0]    delay = '0;
    logic             delay_load = 1'b0;
`ifdef VAR_DELAY_FLUSH_EN
    logic             flush = 1'b0;
`endif
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [DW-1:0]    cur_delay;

    var_delay_line #(
        .WIDTH      (WIDTH),
        .MAX_DELAY  (MAX_DELAY),
        .INIT_DELAY (INIT_DELAY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .delay      (delay),
        .delay_load (delay_load),
`ifdef VAR_DELAY_FLUSH_EN
        .flush      (flush),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .cur_delay  (cur_delay)
    );

    always #5 clk = ~clk;

    smp_t exp_q[$];
    smp_t hist[$];
    smp_t last_exp = '0;
    int   cur_d = int'(INIT_DELAY);
    int   since_load = 0;
    int   n_pass = 0;
    int   n_total = 0;

    // Drive one clock of stimulus, advance the model and queue the expected output.
    task automatic drive(input bit e, input logic [WIDTH-1:0] d, input bit v,
                         input bit ld, input int dly, input bit fl);
        en         = e;
        din        = d;
        din_valid  = v;
        delay_load = ld;
        delay      = DW'(dly);
`ifdef VAR_DELAY_FLUSH_EN
        flush      = fl;
`endif
        if (ld) begin
            cur_d      = (dly > int'(MAX_DELAY)) ? int'(MAX_DELAY) : dly;
            since_load = 0;
        end
        if (fl) begin
            hist.delete();
            since_load = 0;
            last_exp   = '0;
        end else if (e) begin
            if (cur_d == 0) begin
                last_exp = v ? '{d: d, v: 1'b1} : '0;
            end else if (since_load >= cur_d && hist.size() >= cur_d && hist[cur_d-1].v) begin
                last_exp = '{d: hist[cur_d-1].d, v: 1'b1};
            end else begin
                last_exp = '0;
            end
            hist.push_front('{d: d, v: v});
            if (hist.size() > int'(MAX_DELAY)) void'(hist.pop_back());
            since_load++;
        end
        exp_q.push_back(last_exp);
        @(posedge clk);
        #1;
        delay_load = 1'b0;
`ifdef VAR_DELAY_FLUSH_EN
        flush      = 1'b0;
`endif
    endtask

    // Reset with en, load (and flush) also asserted: reset must win.
    task automatic do_reset(input int cycles);
        reset      = 1'b1;
        en         = 1'b1;
        din        = '1;
        din_valid  = 1'b1;
        delay_load = 1'b1;
        delay      = DW'(7);
`ifdef VAR_DELAY_FLUSH_EN
        flush      = 1'b1;
`endif
        repeat (cycles) @(posedge clk);
        #1;
        reset      = 1'b0;
        en         = 1'b0;
        din_valid  = 1'b0;
        delay_load = 1'b0;
`ifdef VAR_DELAY_FLUSH_EN
        flush      = 1'b0;
`endif
        hist.delete();
        since_load = 0;
        cur_d      = int'(INIT_DELAY);
        last_exp   = '0;
        exp_q.push_back(last_exp);
    endtask

    task automatic test_reset();
        smp_t e;
        do_reset(2);
        e = exp_q.pop_front();
        n_total++;
        if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL reset_out: dout=%h valid=%b expected %h/%b", dout, dout_valid, e.d, e.v);
        else n_pass++;
        n_total++;
        if (cur_delay !== DW'(1)) $display("FAIL reset_cur_delay: got %0d expected 1", cur_delay);
        else n_pass++;
    endtask

    task automatic test_fixed_delay();
        smp_t e;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, WIDTH'(k + 1), 1'b1, k == 0, 4, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL fixed_delay k=%0d: dout=%h valid=%b expected %h/%b", k, dout, dout_valid, e.d, e.v);
            else n_pass++;
            if (k == 3 || k == 4) begin
                n_total++;
                if (dout_valid !== (k == 4) || (k == 4 && dout !== WIDTH'(1)))
                    $display("FAIL fixed_delay_first k=%0d: dout=%h valid=%b", k, dout, dout_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sparse_en();
        smp_t e;
        for (int c = 0; c < 30; c++) begin
            drive(c % 3 == 0, WIDTH'($urandom), 1'b1, c == 0, 2, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL sparse_en c=%0d: dout=%h valid=%b expected %h/%b", c, dout, dout_valid, e.d, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_max_wrap();
        smp_t e;
        logic [WIDTH-1:0] s [40];
        for (int k = 0; k < 40; k++) begin
            s[k] = WIDTH'($urandom);
            drive(1'b1, s[k], 1'b1, k == 0, 16, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL max_wrap k=%0d: dout=%h valid=%b expected %h/%b", k, dout, dout_valid, e.d, e.v);
            else n_pass++;
            if (k >= 16) begin
                n_total++;
                if (dout !== s[k-16] || dout_valid !== 1'b1) $display("FAIL max_wrap_direct k=%0d: dout=%h expected %h", k, dout, s[k-16]);
                else n_pass++;
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1, 20, 1'b0);
        e = exp_q.pop_front();
        n_total++;
        if (cur_delay !== DW'(16)) $display("FAIL clamp_load: cur_delay=%0d expected 16", cur_delay);
        else n_pass++;
        n_total++;
        if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL clamp_hold: dout=%h valid=%b expected %h/%b", dout, dout_valid, e.d, e.v);
        else n_pass++;
    endtask

    task automatic test_zero_delay();
        smp_t e;
        drive(1'b1, 24'hABCDEF, 1'b1, 1'b1, 0, 1'b0);
        e = exp_q.pop_front();
        n_total++;
        if (dout !== 24'hABCDEF || dout_valid !== 1'b1 || {dout, dout_valid} !== {e.d, e.v})
            $display("FAIL zero_delay_valid: dout=%h valid=%b expected abcdef/1", dout, dout_valid);
        else n_pass++;
        drive(1'b1, 24'h123456, 1'b0, 1'b0, 0, 1'b0);
        e = exp_q.pop_front();
        n_total++;
        if (dout !== '0 || dout_valid !== 1'b0 || {dout, dout_valid} !== {e.d, e.v})
            $display("FAIL zero_delay_invalid: dout=%h valid=%b expected 0/0", dout, dout_valid);
        else n_pass++;
    endtask

    task automatic test_midstream_load();
        smp_t e;
        logic [WIDTH-1:0] s0 = '0;
        logic [WIDTH-1:0] d;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, WIDTH'($urandom), 1'b1, k == 0, 8, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL mid_pre k=%0d: dout=%h valid=%b expected %h/%b", k, dout, dout_valid, e.d, e.v);
            else n_pass++;
        end
        for (int k = 0; k < 6; k++) begin
            d = WIDTH'($urandom);
            if (k == 0) s0 = d;
            drive(1'b1, d, 1'b1, k == 0, 3, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL mid_post k=%0d: dout=%h valid=%b expected %h/%b", k, dout, dout_valid, e.d, e.v);
            else n_pass++;
            if (k <= 3) begin
                n_total++;
                if (dout_valid !== (k == 3) || (k == 3 && dout !== s0))
                    $display("FAIL mid_post_direct k=%0d: dout=%h valid=%b expected sample %h", k, dout, dout_valid, s0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        smp_t e;
        logic [WIDTH-1:0] s0 = '0;
        logic [WIDTH-1:0] d;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, WIDTH'($urandom), 1'b1, k == 0, 4, 1'b0);
            void'(exp_q.pop_front());
        end
        do_reset(1);
        e = exp_q.pop_front();
        n_total++;
        if (dout !== '0 || dout_valid !== 1'b0 || cur_delay !== DW'(1) || {dout, dout_valid} !== {e.d, e.v})
            $display("FAIL reset_mid: dout=%h valid=%b cur_delay=%0d expected 0/0/1", dout, dout_valid, cur_delay);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            d = WIDTH'($urandom);
            if (k == 0) s0 = d;
            drive(1'b1, d, 1'b1, 1'b0, 0, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL reset_recover k=%0d: dout=%h valid=%b expected %h/%b", k, dout, dout_valid, e.d, e.v);
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if (dout !== s0 || dout_valid !== 1'b1) $display("FAIL reset_recover_direct: dout=%h expected %h", dout, s0);
                else n_pass++;
            end
        end
    endtask

`ifdef VAR_DELAY_FLUSH_EN
    task automatic test_flush();
        smp_t e;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, WIDTH'($urandom), 1'b1, k == 0, 4, 1'b0);
            void'(exp_q.pop_front());
        end
        drive(1'b1, WIDTH'($urandom), 1'b1, 1'b0, 0, 1'b1);
        e = exp_q.pop_front();
        n_total++;
        if (dout !== '0 || dout_valid !== 1'b0 || {dout, dout_valid} !== {e.d, e.v})
            $display("FAIL flush_out: dout=%h valid=%b expected 0/0", dout, dout_valid);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, WIDTH'($urandom), 1'b1, 1'b0, 0, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v} || dout_valid !== (k >= 4))
                $display("FAIL flush_recover k=%0d: dout=%h valid=%b expected %h/%b", k, dout, dout_valid, e.d, e.v);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_back_to_back();
        smp_t e;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 19) == 0, int'($urandom_range(0, 20)), 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if ({dout, dout_valid} !== {e.d, e.v}) $display("FAIL random i=%0d: dout=%h valid=%b expected %h/%b", i, dout, dout_valid, e.d, e.v);
            else n_pass++;
            n_total++;
            if (cur_delay !== DW'(cur_d)) $display("FAIL random_cur_delay i=%0d: got %0d expected %0d", i, cur_delay, cur_d);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed_delay();
        test_sparse_en();
        test_max_wrap();
        test_zero_delay();
        test_midstream_load();
        test_reset_midstream();
`ifdef VAR_DELAY_FLUSH_EN
        test_flush();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
